buzzer_sequencer: RTL and testbench

BUZZER_SEQUENCER -- requirements
Module: buzzer_sequencer

---
 rtl/buzzer_pkg.sv | 29 ++
 rtl/buzzer_tone_gen.sv | 30 +++
 rtl/buzzer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and default tone tables for the buzzer sequencer.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned DEF_N_CH     = 4;
    localparam int unsigned DEF_HP_W     = 17;
    localparam int unsigned DEF_DUR_W    = 10;
    localparam int unsigned DEF_REP_W    = 4;
    localparam int unsigned DEF_TICK_DIV = 50000;

    localparam logic [DEF_HP_W-1:0] HALF_ANSWER   = 17'd95419;
    localparam logic [DEF_HP_W-1:0] HALF_TIMEOVER = 17'd50607;

    // Channel 0 sits in the least significant field of each table.
    localparam logic [DEF_N_CH*DEF_HP_W-1:0] DEF_CH_HALF =
        {HALF_TIMEOVER, HALF_ANSWER, HALF_TIMEOVER, HALF_ANSWER};
    localparam logic [DEF_N_CH*DEF_DUR_W-1:0] DEF_CH_ON =
        {10'd500, 10'd200, 10'd150, 10'd100};
    localparam logic [DEF_N_CH*DEF_DUR_W-1:0] DEF_CH_OFF =
        {10'd250, 10'd100, 10'd100, 10'd100};
    localparam logic [DEF_N_CH*DEF_REP_W-1:0] DEF_CH_REP =
        {4'd1, 4'd3, 4'd2, 4'd1};

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: toggles wave every half+1 enabled cycles, idles high.
module buzzer_tone_gen #(
    parameter int unsigned HP_W = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            clear,
    input  logic [HP_W-1:0] half,
    output logic            wave
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b1;
        end else if (!enable || clear) begin
            cnt  <= '0;
            wave <= 1'b1;
        end else if (cnt == half) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt  <= cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Prioritised multi-channel buzzer pattern player (tone bursts, gaps, repeats).
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned N_CH     = DEF_N_CH,
    parameter int unsigned HP_W     = DEF_HP_W,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned DUR_W    = DEF_DUR_W,
    parameter int unsigned REP_W    = DEF_REP_W,
    parameter logic [N_CH*HP_W-1:0]  CH_HALF = DEF_CH_HALF,
    parameter logic [N_CH*DUR_W-1:0] CH_ON   = DEF_CH_ON,
    parameter logic [N_CH*DUR_W-1:0] CH_OFF  = DEF_CH_OFF,
    parameter logic [N_CH*REP_W-1:0] CH_REP  = DEF_CH_REP,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic [N_CH-1:0] Req,
    input  logic            Stop,
    output logic            Buzzer_Out,
    output logic            Busy,
    output logic [CH_W-1:0] Active_Ch
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            state, nstate;
    logic [N_CH-1:0]   req_q, req_edge, pending, npend, lower, masked;
    logic              armed, entry, busy_q, tick_last, on_done, off_done, seg_done;
    logic [CH_W-1:0]   ch, nch, cand;
    logic [REP_W-1:0]  rep, nrep, rep_cand;
    logic [PRE_W-1:0]  pre;
    logic [DUR_W-1:0]  tick, on_cur, off_cur, on_cand;
    logic [HP_W-1:0]   half_cur;

    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Edge detection is held off for one cycle after reset so a level held through reset is ignored.
    always_comb begin
        req_edge = Req & ~req_q & {N_CH{armed}};
        for (int i = 0; i < int'(N_CH); i++) begin
            lower[i] = (CH_W'(i) < ch);
        end
        masked    = (state == ST_IDLE) ? pending : (pending & lower);
        cand      = lowest_set(masked);
        on_cand   = CH_ON[cand*DUR_W +: DUR_W];
        rep_cand  = CH_REP[cand*REP_W +: REP_W];
        on_cur    = CH_ON[ch*DUR_W +: DUR_W];
        off_cur   = CH_OFF[ch*DUR_W +: DUR_W];
        half_cur  = CH_HALF[ch*HP_W +: HP_W];
        tick_last = (pre == PRE_W'(TICK_DIV - 1));
        on_done   = tick_last && (tick == DUR_W'(on_cur - DUR_W'(1)));
        off_done  = tick_last && (tick == DUR_W'(off_cur - DUR_W'(1)));
        seg_done  = ((state == ST_TONE) && on_done && (off_cur == '0)) ||
                    ((state == ST_GAP) && off_done);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            req_q   <= '0;
            armed   <= 1'b0;
            ch      <= '0;
            rep     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= nstate;
            pending <= npend;
            req_q   <= Req;
            armed   <= 1'b1;
            ch      <= nch;
            rep     <= nrep;
            busy_q  <= (nstate != ST_IDLE);
        end
    end

    // Next state: Stop first, then start/preempt, then segment timing and repeat handling.
    always_comb begin
        nstate = state;
        nch    = ch;
        nrep   = rep;
        npend  = pending | req_edge;
        entry  = 1'b0;
        if (Stop) begin
            nstate = ST_IDLE;
            nch    = '0;
            nrep   = '0;
            npend  = '0;
        end else begin
            case (state)
                ST_IDLE, ST_TONE, ST_GAP: begin
                    if (|masked) npend[cand] = req_edge[cand];
                    if ((|masked) && (on_cand != '0)) begin
                        nstate = ST_TONE;
                        nch    = cand;
                        nrep   = rep_cand;
                        entry  = 1'b1;
                    end else if ((state == ST_TONE) && on_done && (off_cur != '0)) begin
                        nstate = ST_GAP;
                        entry  = 1'b1;
                    end else if (seg_done) begin
                        if (rep == REP_W'(1)) begin
                            nstate = ST_IDLE;
                            nch    = '0;
                            nrep   = '0;
                        end else begin
                            if (rep != '0) nrep = rep - REP_W'(1);
                            nstate = ST_TONE;
                            entry  = 1'b1;
                        end
                    end
                end
                default: begin
                    nstate = ST_IDLE;
                    nch    = '0;
                    nrep   = '0;
                end
            endcase
        end
    end

    // Duration prescaler and tick count, restarted on every state entry.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pre  <= '0;
            tick <= '0;
        end else if (entry || (nstate == ST_IDLE)) begin
            pre  <= '0;
            tick <= '0;
        end else if (tick_last) begin
            pre  <= '0;
            tick <= tick + DUR_W'(1);
        end else begin
            pre  <= pre + PRE_W'(1);
        end
    end

    buzzer_tone_gen #(
        .HP_W (HP_W)
    ) u_tone (
        .clk    (CLK),
        .rst_n  (RST_n),
        .enable (nstate == ST_TONE),
        .clear  (entry),
        .half   (half_cur),
        .wave   (Buzzer_Out)
    );

    assign Busy      = busy_q;
    assign Active_Ch = ch;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with short tick and tone parameters.
module tb_buzzer_sequencer;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [1:0] Req;
    logic       Stop;
    logic       Buzzer_Out;
    logic       Busy;
    logic [0:0] Active_Ch;

    int n_checks = 0;
    int n_errors = 0;

    buzzer_sequencer #(
        .N_CH     (2),
        .HP_W     (17),
        .TICK_DIV (4),
        .DUR_W    (10),
        .REP_W    (4),
        .CH_HALF  ({17'd2, 17'd1}),
        .CH_ON    ({10'd3, 10'd2}),
        .CH_OFF   ({10'd1, 10'd1}),
        .CH_REP   ({4'd0, 4'd2})
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .Req        (Req),
        .Stop       (Stop),
        .Buzzer_Out (Buzzer_Out),
        .Busy       (Busy),
        .Active_Ch  (Active_Ch)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse(input logic [1:0] r);
        Req = r;
        step();
        Req = 2'b00;
    endtask

    task automatic burst(input string tag, input int len, input int half_p, input int ch);
        for (int k = 0; k < len; k++) begin
            chk({tag, "_out"}, 32'(Buzzer_Out), 32'((k % (2 * half_p)) < half_p));
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            chk({tag, "_ch"}, 32'(Active_Ch), 32'(ch));
            step();
        end
    endtask

    task automatic gap(input string tag, input int len);
        for (int k = 0; k < len; k++) begin
            chk({tag, "_out"}, 32'(Buzzer_Out), 32'd1);
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            step();
        end
    endtask

    initial begin
        RST_n = 1'b0;
        Req   = 2'b00;
        Stop  = 1'b0;
        step(2);
        chk("rst_out", 32'(Buzzer_Out), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_ch", 32'(Active_Ch), 32'd0);
        RST_n = 1'b1;
        step(3);
        chk("idle_busy", 32'(Busy), 32'd0);

        // Channel 0: two bursts of 8 cycles, toggling every 2, separated by 4-cycle gaps.
        pulse(2'b01);
        chk("c0_lat1_busy", 32'(Busy), 32'd0);
        step();
        burst("c0_b1", 8, 2, 0);
        gap("c0_g1", 4);
        burst("c0_b2", 8, 2, 0);
        gap("c0_g2", 4);
        chk("c0_end_busy", 32'(Busy), 32'd0);
        chk("c0_end_out", 32'(Buzzer_Out), 32'd1);
        chk("c0_end_ch", 32'(Active_Ch), 32'd0);
        step(3);
        chk("c0_stay_idle", 32'(Busy), 32'd0);

        // Channel 1: endless repeats, period 6, then Stop.
        pulse(2'b10);
        step();
        burst("c1_b1", 12, 3, 1);
        gap("c1_g1", 4);
        chk("c1_rep_busy", 32'(Busy), 32'd1);
        chk("c1_rep_out", 32'(Buzzer_Out), 32'd1);
        step(2);
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        chk("c1_stop_busy", 32'(Busy), 32'd0);
        chk("c1_stop_out", 32'(Buzzer_Out), 32'd1);
        chk("c1_stop_ch", 32'(Active_Ch), 32'd0);
        step(4);
        chk("c1_stop_hold", 32'(Busy), 32'd0);

        // Preemption of channel 1 by channel 0 mid-tone.
        pulse(2'b10);
        step(5);
        chk("pre_c1_out", 32'(Buzzer_Out), 32'd0);
        chk("pre_c1_ch", 32'(Active_Ch), 32'd1);
        pulse(2'b01);
        chk("pre_pend_ch", 32'(Active_Ch), 32'd1);
        step();
        burst("pre_b1", 8, 2, 0);
        gap("pre_g1", 4);
        burst("pre_b2", 8, 2, 0);
        gap("pre_g2", 4);
        chk("pre_end_busy", 32'(Busy), 32'd0);
        step(3);
        chk("pre_no_resume", 32'(Busy), 32'd0);

        // Simultaneous requests: channel 0 first, channel 1 one cycle after idle.
        pulse(2'b11);
        step();
        burst("sim_b1", 8, 2, 0);
        gap("sim_g1", 4);
        burst("sim_b2", 8, 2, 0);
        gap("sim_g2", 4);
        chk("sim_idle_busy", 32'(Busy), 32'd0);
        chk("sim_idle_ch", 32'(Active_Ch), 32'd0);
        step();
        chk("sim_c1_busy", 32'(Busy), 32'd1);
        chk("sim_c1_ch", 32'(Active_Ch), 32'd1);
        chk("sim_c1_out", 32'(Buzzer_Out), 32'd1);
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        chk("sim_stop_busy", 32'(Busy), 32'd0);

        // A request edge coincident with Stop is dropped.
        Req  = 2'b01;
        Stop = 1'b1;
        step();
        Req  = 2'b00;
        Stop = 1'b0;
        step(3);
        chk("stop_drop_busy", 32'(Busy), 32'd0);

        // Reset mid-tone while Req is held high through and after reset.
        Req = 2'b10;
        step(2);
        chk("rsttone_busy", 32'(Busy), 32'd1);
        step(3);
        chk("rsttone_out_lo", 32'(Buzzer_Out), 32'd0);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_out", 32'(Buzzer_Out), 32'd1);
        chk("async_busy", 32'(Busy), 32'd0);
        chk("async_ch", 32'(Active_Ch), 32'd0);
        step(2);
        RST_n = 1'b1;
        step(8);
        chk("held_req_busy", 32'(Busy), 32'd0);
        chk("held_req_out", 32'(Buzzer_Out), 32'd1);
        Req = 2'b00;
        step();
        Req = 2'b10;
        step(2);
        chk("fresh_edge_busy", 32'(Busy), 32'd1);
        chk("fresh_edge_ch", 32'(Active_Ch), 32'd1);
        Req  = 2'b00;
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        chk("final_stop_busy", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
